ps2_rx_fifo: RTL and testbench
==============================

# ps2_rx_fifo

Parametrised PS/2 keyboard receiver. It deserialises 11-bit PS/2 frames from the keyboard lines into a DEPTH-entry show-ahead FIFO for the system clock domain. Compared with the previous receiver it adds frame validation and a watchdog that aborts stalled frames, and it pops exactly once per read strobe. It sits between the keyboard pins and the scan-code decoder / display logic.

## Interface
- DEPTH, 8: FIFO entries; must be a power of two, ≥2.
- SYNC_STAGES, 2: flip-flop synchroniser depth on ps2_clk and ps2_data; must be ≥2.
- TIMEOUT_CYC, 5000: clk cycles without a ps2_clk falling edge before a partial frame is aborted.

- clk  in  1  system clock. One clock domain only.
- clrn  in  1  reset. Asynchronous, active-low.
- ps2_clk  in  1  keyboard clock line. Asynchronous to clk.
- ps2_data  in  1  keyboard data line. Asynchronous to clk.
- nextdata_n  in  1  read strobe, active-low. Exactly one pop per high→low transition.
- data  out  8  FIFO head byte (show-ahead). Holds the last value when empty.
- ready  out  1  FIFO not empty.
- overflow  out  1  sticky: a valid byte was dropped because the FIFO was full.
- frame_err  out  1  one-cycle pulse on each rejected or aborted frame.
- count  out  $clog2(DEPTH)+1  number of occupied entries.

## Operation
- ps2_clk and ps2_data each pass through a SYNC_STAGES synchroniser.
- A falling edge (fe) is a synchronised ps2_clk change from 1 to 0, detected with one extra register. ps2_data is sampled on fe.
- FSM:
  - IDLE: on fe with data=0 (start bit), go to RECV and set bitcnt=1. On fe with data=1, stay in IDLE.
  - RECV: each fe shifts one bit in, LSB first, and increments bitcnt. When bitcnt reaches 11, go to CHECK.
  - CHECK: lasts one cycle. The frame is valid when stop=1 and the parity rule passes. A valid frame is pushed. An invalid frame pulses frame_err. Go to IDLE.
- Watchdog: in RECV, a counter resets on every fe. When it reaches TIMEOUT_CYC-1, the FSM goes to IDLE, discards the partial frame, and pulses frame_err.
- Push rules:
  - Push into a full FIFO with no pop in the same cycle: byte dropped, overflow set.
  - Push and pop in the same cycle: both take effect and count is unchanged. This includes the full case, and no overflow is raised.
- Pop:
  - Taken when ready=1 and a strobe edge is seen: nextdata_n_q=1 and nextdata_n=0.
  - A strobe edge with ready=0 is ignored and is not remembered.
  - overflow clears on the first pop after it was set.
- Pointers are $clog2(DEPTH)+1 bits and wrap naturally. Empty when the pointers are equal. Full when the MSBs differ and the other bits are equal.

## Timing
- Reset values: data=8'h00, ready=0, overflow=0, frame_err=0, count=0. FSM in IDLE, nextdata_n_q=1, synchroniser stages at 1.
- Pin fall → fe: SYNC_STAGES+1 clk cycles.
- 11th fe → CHECK on the next edge. Push is written at the end of the CHECK cycle, so ready, count and data update 2 cycles after the 11th fe.
- Pop: nextdata_n sampled low at edge k (with nextdata_n_q=1) → rd_ptr advances at k. data and count update from k. ready falls at k if that was the last entry.
- frame_err is high for exactly one clk cycle per event.
- clrn asserted mid-frame or mid-read: everything returns to reset values at once, and the partial frame is lost. After release, the receiver waits for the next start bit.

## Configuration
- PS2_PARITY_CHECK_EN defined: odd parity is checked, so XOR of the 8 data bits and the parity bit must be 1. A failing frame is dropped with frame_err.
- PS2_PARITY_CHECK_EN undefined: the parity bit is captured but ignored. Only the stop bit is checked.

## Structure
- Package ps2_pkg holds:
  - FRAME_BITS=11
  - the FSM state enum {IDLE, RECV, CHECK}
  - the function odd_parity_ok(data, par)
- Sub-module ps2_sync_fifo (parameters DEPTH and width 8) holds the storage, pointers, count, full/empty logic and the simultaneous push/pop rules. The top holds the synchroniser, FSM, watchdog and strobe-edge detection.

## Test plan
- Reset, send 8'h1C, then pulse nextdata_n low for 2 cycles → ready=1 and data=8'h1C before the pulse. Exactly one pop, then ready=0 and count=0.
- Send 8'h1C, 8'hF0, 8'h1C with no reads → count=3 and data=8'h1C. Three strobes return 1C, F0, 1C in that order, then ready=0.
- DEPTH=8: send 9 bytes 8'h01..8'h09 with no reads → count=8 and overflow=1, and 8'h09 is lost. The first pop returns 8'h01 and clears overflow.
- With PS2_PARITY_CHECK_EN, send 8'h1B with a wrong parity bit → one frame_err pulse, count unchanged. Without the macro → 8'h1B is pushed.
- Send 5 bits then stall ps2_clk for TIMEOUT_CYC cycles → frame_err pulse and FSM in IDLE. The next full frame 8'h1B is received correctly.
- Full FIFO: a push and a strobe edge land in the same cycle → count stays at DEPTH, overflow=0, head advances.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: frame length, receiver
// FSM states and the odd-parity rule applied to a received byte.
package ps2_pkg;

  localparam int FRAME_BITS = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

  // Odd parity: the 8 data bits plus the parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// Show-ahead FIFO for received scan codes. Pointers carry one extra wrap
// bit so full and empty are distinguishable. A push into a full FIFO is
// accepted only when a pop happens in the same cycle; otherwise the byte
// is dropped and the sticky overflow flag is raised until the next pop.
module ps2_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     ready,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             ovf_q, ovf_d;
  logic             empty, full, do_pop, do_push, drop;

  // Pointer arithmetic, simultaneous push/pop rules and the held output value.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    drop     = push && full && !do_pop;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    mem_d    = mem_q;
    if (do_push) mem_d[wr_ptr_q[AW-1:0]] = wdata;
    last_d   = do_pop ? mem_q[rd_ptr_q[AW-1:0]] : last_q;
    ovf_d    = ovf_q;
    if (drop)        ovf_d = 1'b1;
    else if (do_pop) ovf_d = 1'b0;
    rdata    = empty ? last_q : mem_q[rd_ptr_q[AW-1:0]];
    ready    = !empty;
    overflow = ovf_q;
    count    = wr_ptr_q - rd_ptr_q;
  end

  // Storage, pointers, last-popped byte and sticky overflow.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      last_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      last_q   <= last_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronises the keyboard lines, deserialises
// 11-bit frames (start, 8 data LSB first, parity, stop), validates them,
// aborts stalled frames with a watchdog and queues good bytes in a FIFO.
// Build option: define PS2_PARITY_CHECK_EN to reject frames whose odd
// parity is wrong; otherwise only the stop bit is checked.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic                   clk,
  input  logic                   clrn,
  input  logic                   ps2_clk,
  input  logic                   ps2_data,
  input  logic                   nextdata_n,
  output logic [7:0]             data,
  output logic                   ready,
  output logic                   overflow,
  output logic                   frame_err,
  output logic [$clog2(DEPTH):0] count
);

  localparam int WDW = $clog2(TIMEOUT_CYC) + 1;

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic                   nextdata_n_q, nextdata_n_d;
  state_t                 state_q, state_d;
  logic [3:0]             bitcnt_q, bitcnt_d;
  logic [9:0]             shift_q, shift_d;
  logic [WDW-1:0]         wd_q, wd_d;
  logic                   frame_err_q, frame_err_d;
  logic                   ps2_clk_s, ps2_data_s, fe, push, pop, parity_ok;

  // Synchronisers, ps2_clk falling-edge detect and read-strobe edge detect.
  always_comb begin
    clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    dat_sync_d   = {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
    ps2_clk_s    = clk_sync_q[SYNC_STAGES-1];
    ps2_data_s   = dat_sync_q[SYNC_STAGES-1];
    clk_prev_d   = ps2_clk_s;
    fe           = clk_prev_q && !ps2_clk_s;
    nextdata_n_d = nextdata_n;
    pop          = ready && nextdata_n_q && !nextdata_n;
  end

  // Frame validity: stop bit always, odd parity only when enabled.
  always_comb begin
`ifdef PS2_PARITY_CHECK_EN
    parity_ok = odd_parity_ok(shift_q[7:0], shift_q[8]);
`else
    // Parity bit is captured in the shift register but never enforced.
    parity_ok = odd_parity_ok(shift_q[7:0], shift_q[8]) | 1'b1;
`endif
  end

  // Receiver FSM with watchdog: shift bits on fe, judge the frame in CHECK.
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    wd_d        = '0;
    push        = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (fe && !ps2_data_s) begin
          state_d  = RECV;
          bitcnt_d = 4'd1;
        end
      end
      RECV: begin
        if (fe) begin
          shift_d  = {ps2_data_s, shift_q[9:1]};
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_d == 4'(FRAME_BITS)) state_d = CHECK;
        end else if (wd_q == WDW'(TIMEOUT_CYC - 1)) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      CHECK: begin
        if (shift_q[9] && parity_ok) push = 1'b1;
        else                         frame_err_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and shift registers; synchroniser stages idle high.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync_q   <= '1;
      dat_sync_q   <= '1;
      clk_prev_q   <= 1'b1;
      nextdata_n_q <= 1'b1;
      state_q      <= IDLE;
      bitcnt_q     <= '0;
      shift_q      <= '0;
      wd_q         <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      clk_sync_q   <= clk_sync_d;
      dat_sync_q   <= dat_sync_d;
      clk_prev_q   <= clk_prev_d;
      nextdata_n_q <= nextdata_n_d;
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      shift_q      <= shift_d;
      wd_q         <= wd_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign frame_err = frame_err_q;

  ps2_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk      (clk),
    .clrn     (clrn),
    .push     (push),
    .wdata    (shift_q[7:0]),
    .pop      (pop),
    .rdata    (data),
    .ready    (ready),
    .overflow (overflow),
    .count    (count)
  );

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: directed scenarios plus randomized
// frames and reads, compared against a queue-based reference model.
module tb_ps2_rx_fifo;

  localparam int DEPTH       = 8;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT_CYC = 200;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic clrn, ps2_clk, ps2_data, nextdata_n;
  logic [7:0] data;
  logic ready, overflow, frame_err;
  logic [$clog2(DEPTH):0] count;

  always #5 clk = ~clk;

  ps2_rx_fifo #(
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .nextdata_n (nextdata_n),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow),
    .frame_err  (frame_err),
    .count      (count)
  );

  int total = 0;
  int passed = 0;

  // Reference model
  logic [7:0] model_q[$];
  logic [7:0] model_last = 8'h00;
  bit         model_ovf = 1'b0;
  int         model_err = 0;
  logic [7:0] exp_d;

  // frame_err monitor: high-cycle count and pulse count
  int   err_hi = 0;
  int   err_rise = 0;
  logic err_prev = 1'b0;
  always @(negedge clk) begin
    if (!clrn) begin
      err_prev <= 1'b0;
    end else begin
      if (frame_err) err_hi <= err_hi + 1;
      if (frame_err && !err_prev) err_rise <= err_rise + 1;
      err_prev <= frame_err;
    end
  end

  function automatic void model_push(input logic [7:0] b);
    if (model_q.size() < DEPTH) model_q.push_back(b);
    else model_ovf = 1'b1;
  endfunction

  function automatic void model_pop();
    if (model_q.size() > 0) begin
      model_last = model_q.pop_front();
      model_ovf  = 1'b0;
    end
  endfunction

  function automatic logic [7:0] model_head();
    return (model_q.size() > 0) ? model_q[0] : model_last;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive nbits of a frame; optionally strobe a read so the pop lands on the push edge.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit strobe, input int nbits);
    logic [10:0] fr;
    int h;
    h  = $urandom_range(6, 12);
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      cycles(h);
      ps2_clk = 1'b0;
      for (int c = 0; c < h; c++) begin
        @(negedge clk);
        if (strobe && i == 10 && c == SYNC_STAGES)     nextdata_n = 1'b0;
        if (strobe && i == 10 && c == SYNC_STAGES + 1) nextdata_n = 1'b1;
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    cycles(h + 4);
  endtask

  task automatic send_and_model(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    send_frame(b, bad_par, bad_stop, 1'b0, 11);
    if (bad_stop || (PAR_EN && bad_par)) model_err++;
    else model_push(b);
  endtask

  task automatic do_read(input int len);
    nextdata_n = 1'b0;
    cycles(len);
    nextdata_n = 1'b1;
    model_pop();
    cycles(1);
  endtask

  task automatic test_reset();
    clrn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; nextdata_n = 1'b1;
    cycles(3);
    total++; if (data !== 8'h00) $display("FAIL reset_data: got %h want 00", data); else passed++;
    total++; if (ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", ready); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else passed++;
    total++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", frame_err); else passed++;
    total++; if (count !== 0) $display("FAIL reset_count: got %0d want 0", count); else passed++;
    clrn = 1'b1;
    cycles(5);
    total++; if (ready !== 1'b0) $display("FAIL post_reset_ready: got %b want 0", ready); else passed++;
  endtask

  task automatic test_single();
    send_and_model(8'h1C, 1'b0, 1'b0);
    total++; if (ready !== 1'b1) $display("FAIL single_ready: got %b want 1", ready); else passed++;
    total++; if (data !== 8'h1C) $display("FAIL single_data: got %h want 1c", data); else passed++;
    do_read(2);
    total++; if (ready !== 1'b0) $display("FAIL single_ready_after: got %b want 0", ready); else passed++;
    total++; if (count !== 0) $display("FAIL single_count_after: got %0d want 0", count); else passed++;
    total++; if (data !== 8'h1C) $display("FAIL single_data_held: got %h want 1c", data); else passed++;
  endtask

  task automatic test_three();
    logic [7:0] seq [3];
    seq[0] = 8'h1C; seq[1] = 8'hF0; seq[2] = 8'h1C;
    for (int k = 0; k < 3; k++) send_and_model(seq[k], 1'b0, 1'b0);
    total++; if (count !== 3) $display("FAIL three_count: got %0d want 3", count); else passed++;
    for (int k = 0; k < 3; k++) begin
      total++; if (data !== seq[k]) $display("FAIL three_head%0d: got %h want %h", k, data, seq[k]); else passed++;
      do_read(1 + k % 2);
    end
    total++; if (ready !== 1'b0) $display("FAIL three_ready_end: got %b want 0", ready); else passed++;
  endtask

  task automatic test_overflow();
    for (int k = 1; k <= 9; k++) send_and_model(8'(k), 1'b0, 1'b0);
    total++; if (count !== DEPTH) $display("FAIL ovf_count: got %0d want %0d", count, DEPTH); else passed++;
    total++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow); else passed++;
    total++; if (data !== 8'h01) $display("FAIL ovf_head: got %h want 01", data); else passed++;
    do_read(1);
    total++; if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", overflow); else passed++;
    total++; if (data !== 8'h02) $display("FAIL ovf_head2: got %h want 02", data); else passed++;
    while (model_q.size() > 0) begin
      exp_d = model_head();
      total++; if (data !== exp_d) $display("FAIL ovf_drain: got %h want %h", data, exp_d); else passed++;
      do_read(1);
    end
    total++; if (data !== 8'h08) $display("FAIL ovf_last: got %h want 08 (09 must be lost)", data); else passed++;
  endtask

  task automatic test_parity();
    send_and_model(8'h1B, 1'b1, 1'b0);
    total++; if (err_rise !== model_err) $display("FAIL par_err_pulses: got %0d want %0d", err_rise, model_err); else passed++;
    total++; if (count !== model_q.size()) $display("FAIL par_count: got %0d want %0d", count, model_q.size()); else passed++;
    exp_d = model_head();
    total++; if (data !== exp_d) $display("FAIL par_data: got %h want %h", data, exp_d); else passed++;
    send_and_model(8'h2A, 1'b0, 1'b1);
    total++; if (err_rise !== model_err) $display("FAIL stop_err_pulses: got %0d want %0d", err_rise, model_err); else passed++;
    total++; if (err_hi !== model_err) $display("FAIL stop_err_width: got %0d high cycles want %0d", err_hi, model_err); else passed++;
    total++; if (count !== model_q.size()) $display("FAIL stop_count: got %0d want %0d", count, model_q.size()); else passed++;
    while (model_q.size() > 0) do_read(1);
  endtask

  task automatic test_timeout();
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 5);
    cycles(TIMEOUT_CYC + 20);
    model_err++;
    total++; if (err_rise !== model_err) $display("FAIL wd_err_pulses: got %0d want %0d", err_rise, model_err); else passed++;
    total++; if (count !== 0) $display("FAIL wd_count: got %0d want 0", count); else passed++;
    send_and_model(8'h1B, 1'b0, 1'b0);
    total++; if (count !== 1) $display("FAIL wd_next_count: got %0d want 1", count); else passed++;
    total++; if (data !== 8'h1B) $display("FAIL wd_next_data: got %h want 1b", data); else passed++;
    total++; if (err_rise !== model_err) $display("FAIL wd_next_err: got %0d want %0d", err_rise, model_err); else passed++;
    while (model_q.size() > 0) do_read(1);
  endtask

  task automatic test_full_simul();
    logic [7:0] b9;
    for (int k = 0; k < DEPTH; k++) send_and_model(8'($urandom), 1'b0, 1'b0);
    total++; if (count !== DEPTH) $display("FAIL full_count_pre: got %0d want %0d", count, DEPTH); else passed++;
    b9 = 8'($urandom);
    send_frame(b9, 1'b0, 1'b0, 1'b1, 11);
    model_pop();
    model_push(b9);
    total++; if (count !== DEPTH) $display("FAIL full_count_post: got %0d want %0d", count, DEPTH); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL full_overflow: got %b want 0", overflow); else passed++;
    for (int k = 0; k < DEPTH; k++) begin
      exp_d = model_head();
      total++; if (data !== exp_d) $display("FAIL full_drain%0d: got %h want %h", k, data, exp_d); else passed++;
      do_read(1);
    end
  endtask

  task automatic test_reset_midframe();
    send_and_model(8'hA5, 1'b0, 1'b0);
    send_and_model(8'h3C, 1'b0, 1'b0);
    send_frame(8'h77, 1'b0, 1'b0, 1'b0, 4);
    clrn = 1'b0;
    cycles(2);
    model_q.delete(); model_last = 8'h00; model_ovf = 1'b0;
    total++; if (count !== 0) $display("FAIL rst_mid_count: got %0d want 0", count); else passed++;
    total++; if (data !== 8'h00) $display("FAIL rst_mid_data: got %h want 00", data); else passed++;
    total++; if (ready !== 1'b0) $display("FAIL rst_mid_ready: got %b want 0", ready); else passed++;
    clrn = 1'b1;
    cycles(5);
    send_and_model(8'h1B, 1'b0, 1'b0);
    total++; if (count !== 1) $display("FAIL rst_mid_next_count: got %0d want 1", count); else passed++;
    total++; if (data !== 8'h1B) $display("FAIL rst_mid_next_data: got %h want 1b", data); else passed++;
    while (model_q.size() > 0) do_read(1);
  endtask

  task automatic test_random();
    int r, nr;
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      send_and_model(8'($urandom), r == 1, r == 0);
      exp_d = model_head();
      total++; if (data !== exp_d) $display("FAIL rnd_data it%0d: got %h want %h", it, data, exp_d); else passed++;
      total++; if (count !== model_q.size()) $display("FAIL rnd_count it%0d: got %0d want %0d", it, count, model_q.size()); else passed++;
      total++; if (overflow !== model_ovf) $display("FAIL rnd_ovf it%0d: got %b want %b", it, overflow, model_ovf); else passed++;
      total++; if (err_rise !== model_err) $display("FAIL rnd_err it%0d: got %0d want %0d", it, err_rise, model_err); else passed++;
      nr = $urandom_range(0, 2);
      for (int j = 0; j < nr; j++) do_read($urandom_range(1, 3));
      total++; if (ready !== (model_q.size() > 0)) $display("FAIL rnd_ready it%0d: got %b want %b", it, ready, model_q.size() > 0); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_three();
    test_overflow();
    test_parity();
    test_timeout();
    test_full_simul();
    test_reset_midframe();
    test_random();
    total++; if (err_hi !== model_err) $display("FAIL err_width_total: got %0d high cycles want %0d", err_hi, model_err); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
